// File: rtl/lmem_pkg.sv
// Shared response codes, read FSM encoding and address range check for the lmem responder.
package lmem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} lmem_rd_state_t;

  // Offset wraps at 32 bits, so addresses below base land far out of range.
  function automatic logic lmem_addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [2:0] size, input int unsigned depth);
    return (((addr - base) >> 3) < depth) && (size <= 3'd3);
  endfunction

endpackage

// File: rtl/lmem_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that paces ready/valid stalls; advances every cycle,
// no handshake of its own.
module lmem_stall_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= seed;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

endmodule

// File: rtl/axi_lmem_responder.sv
// AXI4 local-memory slave: B 2 cycles after AW+W, R RD_LAT cycles after AR; 1 read / 1 write in flight,
// valids held until ready. LMEM_STALL_INJECT_EN adds LFSR-driven ready/valid stalls.
module axi_lmem_responder
  import lmem_pkg::*;
#(
  parameter int          TAG       = 1,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           awvalid,
  output logic           awready,
  input  logic [TAG-1:0] awid,
  input  logic [31:0]    awaddr,
  input  logic [2:0]     awsize,
  input  logic           wvalid,
  output logic           wready,
  input  logic [63:0]    wdata,
  input  logic [7:0]     wstrb,
  output logic           bvalid,
  input  logic           bready,
  output logic [TAG-1:0] bid,
  output logic [1:0]     bresp,
  input  logic           arvalid,
  output logic           arready,
  input  logic [TAG-1:0] arid,
  input  logic [31:0]    araddr,
  input  logic [2:0]     arsize,
  output logic           rvalid,
  input  logic           rready,
  output logic [TAG-1:0] rid,
  output logic [63:0]    rdata,
  output logic [1:0]     rresp,
  output logic           rlast
);

  localparam int IDXW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG-1:0]  id;
    logic            ok;
    logic [IDXW-1:0] idx;
  } req_t;

  function automatic req_t decode(input logic [TAG-1:0] id, input logic [31:0] addr,
                                  input logic [2:0] size);
    req_t r;
    r.id  = id;
    r.ok  = lmem_addr_ok(addr, BASE_ADDR, size, DEPTH);
    r.idx = IDXW'((addr - BASE_ADDR) >> 3);
    return r;
  endfunction

  logic [63:0] mem [DEPTH];

  logic go_aw, go_w, go_ar, go_rsp;
`ifdef LMEM_STALL_INJECT_EN
  logic [15:0] lfsr;
  lmem_stall_lfsr u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .lfsr(lfsr));
  assign go_aw  = lfsr[0];
  assign go_w   = lfsr[1];
  assign go_ar  = lfsr[2];
  assign go_rsp = lfsr[3];
`else
  assign go_aw  = 1'b1;
  assign go_w   = 1'b1;
  assign go_ar  = 1'b1;
  assign go_rsp = 1'b1;
`endif

  // ---------------- write path ----------------
  req_t        aw_q;
  logic        aw_held, w_held, aw_hs, w_hs, commit;
  logic [63:0] w_dat;
  logic [7:0]  w_stb;

  assign awready = !aw_held && go_aw;
  assign wready  = !w_held && go_w;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign commit  = aw_held && w_held && !bvalid && go_rsp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      w_dat   <= '0;
      w_stb   <= '0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= AXI_RESP_OKAY;
    end else begin
      if (commit) aw_held <= 1'b0;
      else if (aw_hs) begin
        aw_held <= 1'b1;
        aw_q    <= decode(awid, awaddr, awsize);
      end
      if (commit) w_held <= 1'b0;
      else if (w_hs) begin
        w_held <= 1'b1;
        w_dat  <= wdata;
        w_stb  <= wstrb;
      end
      if (commit) begin
        bvalid <= 1'b1;
        bid    <= aw_q.id;
        bresp  <= aw_q.ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && aw_q.ok)
      for (int i = 0; i < 8; i++)
        if (w_stb[i]) mem[aw_q.idx][8*i +: 8] <= w_dat[8*i +: 8];
  end

  // ---------------- read path ----------------
  lmem_rd_state_t state, state_nxt;
  req_t           rd_q, rd_cur;
  logic [3:0]     cnt;
  logic [63:0]    rd_word;
  logic           ar_hs;

  assign ar_hs  = arvalid && arready;
  // With RD_LAT=1 the request is still on the AR bus when rdata is captured.
  assign rd_cur = (state == RD_IDLE) ? decode(arid, araddr, arsize) : rd_q;

  // Write-first: a same-cycle commit to the word being captured wins per strobed byte.
  always_comb begin
    rd_word = mem[rd_cur.idx];
    if (commit && aw_q.ok && (aw_q.idx == rd_cur.idx))
      for (int i = 0; i < 8; i++)
        if (w_stb[i]) rd_word[8*i +: 8] = w_dat[8*i +: 8];
    if (!rd_cur.ok) rd_word = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: if (ar_hs) state_nxt = (RD_LAT == 1 && go_rsp) ? RD_RESP : RD_WAIT;
      RD_WAIT: if (cnt == 4'd0 && go_rsp) state_nxt = RD_RESP;
      RD_RESP: if (rready) state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    arready = (state == RD_IDLE) && go_ar;
    rvalid  = (state == RD_RESP);
    rlast   = rvalid;
    rid     = rd_q.id;
    rresp   = (rvalid && !rd_q.ok) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      if (ar_hs) begin
        rd_q <= rd_cur;
        cnt  <= (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;
      end else if (state == RD_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == RD_RESP && state != RD_RESP) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_axi_lmem_responder.sv
// Scoreboard bench for axi_lmem_responder: directed writes/reads push expected B/R beats,
// a negedge monitor pops and compares them and checks valid/payload stability under backpressure.
module tb_axi_lmem_responder;
  import lmem_pkg::*;

  localparam int TAG    = 1;
  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready, rlast;
  logic [TAG-1:0] awid, bid, arid, rid;
  logic [31:0]    awaddr, araddr;
  logic [2:0]     awsize, arsize;
  logic [63:0]    wdata, rdata;
  logic [7:0]     wstrb;
  logic [1:0]     bresp, rresp;

  always #5 clk = ~clk;

  axi_lmem_responder #(.TAG(TAG), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(RD_LAT),
                       .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct packed {logic [TAG-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [TAG-1:0] id; logic [63:0] data; logic [1:0] resp;} r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  b_exp_t be;
  r_exp_t re;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic stop_run(input string nm);
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  endtask

  // ---------------- monitor ----------------
  logic           pb_stall = 1'b0, pr_stall = 1'b0;
  logic [TAG-1:0] pbid, prid;
  logic [1:0]     pbresp, prresp;
  logic [63:0]    prdata;

  always @(negedge clk) begin
    if (rst) begin
      pb_stall <= 1'b0;
      pr_stall <= 1'b0;
    end else begin
      if (pb_stall) begin
        check("b_hold_valid", 64'(bvalid), 64'd1);
        check("b_hold_id", 64'(bid), 64'(pbid));
        check("b_hold_resp", 64'(bresp), 64'(pbresp));
      end
      if (bvalid && bready) begin
        n_cmp++;
        if (b_q.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected: got bid %0d, expected no response", bid);
        end else begin
          n_cmp--;
          be = b_q.pop_front();
          check("bid", 64'(bid), 64'(be.id));
          check("bresp", 64'(bresp), 64'(be.resp));
        end
      end
      pb_stall <= bvalid && !bready;
      pbid     <= bid;
      pbresp   <= bresp;

      if (pr_stall) begin
        check("r_hold_valid", 64'(rvalid), 64'd1);
        check("r_hold_data", rdata, prdata);
        check("r_hold_id", 64'(rid), 64'(prid));
        check("r_hold_resp", 64'(rresp), 64'(prresp));
      end
      if (rvalid && rready) begin
        n_cmp++;
        if (r_q.size() == 0) begin
          n_err++;
          $display("FAIL r_unexpected: got rdata %h, expected no response", rdata);
        end else begin
          n_cmp--;
          re = r_q.pop_front();
          check("rid", 64'(rid), 64'(re.id));
          check("rdata", rdata, re.data);
          check("rresp", 64'(rresp), 64'(re.resp));
          check("rlast", 64'(rlast), 64'd1);
        end
      end
      pr_stall <= rvalid && !rready;
      prid     <= rid;
      prdata   <= rdata;
      prresp   <= rresp;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [TAG-1:0] id, input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] data, input logic [7:0] strb, input logic [1:0] resp,
                          input bit chk_lat);
    int t;
    bit aw_hs, w_hs, aw_done, w_done;
    b_q.push_back('{id: id, resp: resp});
    awvalid = 1'b1; awid = id; awaddr = addr; awsize = size;
    wvalid  = 1'b1; wdata = data; wstrb = strb;
    aw_done = 1'b0; w_done = 1'b0; t = 0;
    while (!(aw_done && w_done)) begin
      if (t == 50) stop_run("write_accept");
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      t++;
    end
    t = 1;
    while (!bvalid) begin
      if (t == 50) stop_run("b_wait");
      @(posedge clk); #1;
      t++;
    end
    if (chk_lat) check("b_latency", 64'(t), 64'd2);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [TAG-1:0] id, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] data, input logic [1:0] resp, input bit chk_lat);
    int t;
    bit hs;
    r_q.push_back('{id: id, data: data, resp: resp});
    arvalid = 1'b1; arid = id; araddr = addr; arsize = size;
    hs = 1'b0; t = 0;
    while (!hs) begin
      if (t == 50) stop_run("ar_accept");
      hs = arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 1'b0;
    t = 1;
    while (!rvalid) begin
      if (t == 50) stop_run("r_wait");
      @(posedge clk); #1;
      t++;
    end
    if (chk_lat) begin
      check("r_latency", 64'(t), 64'(RD_LAT));
      check("arready_busy", 64'(arready), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    stop_run("global_watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 1'b0; awid = '0; awaddr = '0; awsize = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0;
    arvalid = 1'b0; arid = '0; araddr = '0; arsize = '0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
`ifndef LMEM_STALL_INJECT_EN
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
`endif
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef LMEM_STALL_INJECT_EN
    begin
      logic [63:0] d;
      logic [31:0] a;
      for (int i = 0; i < 200; i++) begin
        d = {$urandom(), $urandom()};
        a = 32'($urandom_range(0, 255)) << 3;
        do_write(TAG'(i % 2), a, 3'd3, d, 8'hFF, AXI_RESP_OKAY, 1'b0);
        do_read(TAG'((i + 1) % 2), a, 3'd3, d, AXI_RESP_OKAY, 1'b0);
      end
    end
`else
    // basic write then read with latency checks
    do_write(1'b1, 32'h40, 3'd3, 64'h1122334455667788, 8'hFF, AXI_RESP_OKAY, 1'b1);
    do_read(1'b0, 32'h40, 3'd3, 64'h1122334455667788, AXI_RESP_OKAY, 1'b1);

    // strobes
    do_write(1'b0, 32'h10, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, AXI_RESP_OKAY, 1'b0);
    do_write(1'b1, 32'h10, 3'd3, 64'h0, 8'h0F, AXI_RESP_OKAY, 1'b0);
    do_read(1'b1, 32'h10, 3'd3, 64'hFFFF_FFFF_0000_0000, AXI_RESP_OKAY, 1'b1);
    do_write(1'b0, 32'h18, 3'd3, 64'h0, 8'hFF, AXI_RESP_OKAY, 1'b0);
    do_write(1'b0, 32'h18, 3'd2, 64'h0102_0304_0506_0708, 8'hA5, AXI_RESP_OKAY, 1'b0);
    do_read(1'b1, 32'h1F, 3'd3, 64'h0100_0300_0006_0008, AXI_RESP_OKAY, 1'b0);

    // W three cycles ahead of AW, B held under backpressure, second write queued behind it
    bready = 1'b0;
    wvalid = 1'b1; wdata = 64'hCAFE_F00D_1234_5678; wstrb = 8'hFF;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wready_held", 64'(wready), 64'd0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    b_q.push_back('{id: 1'b1, resp: AXI_RESP_OKAY});
    awvalid = 1'b1; awid = 1'b1; awaddr = 32'h20; awsize = 3'd3;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("b_not_yet", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    check("b_after_aw", 64'(bvalid), 64'd1);
    check("b_after_aw_id", 64'(bid), 64'd1);
    check("wready_freed", 64'(wready), 64'd1);
    b_q.push_back('{id: 1'b0, resp: AXI_RESP_OKAY});
    awvalid = 1'b1; awid = 1'b0; awaddr = 32'h28; awsize = 3'd3;
    wvalid = 1'b1; wdata = 64'h0BAD_BEEF_0000_0042; wstrb = 8'hFF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("awready_full", 64'(awready), 64'd0);
    check("wready_full", 64'(wready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("b_still_first", 64'(bid), 64'd1);
    bready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_read(1'b0, 32'h20, 3'd3, 64'hCAFE_F00D_1234_5678, AXI_RESP_OKAY, 1'b0);
    do_read(1'b1, 32'h28, 3'd3, 64'h0BAD_BEEF_0000_0042, AXI_RESP_OKAY, 1'b0);

    // errors and boundaries
    do_read(1'b1, 32'h8000, 3'd3, 64'h0, AXI_RESP_SLVERR, 1'b1);
    do_read(1'b0, 32'h40, 3'd4, 64'h0, AXI_RESP_SLVERR, 1'b0);
    do_write(1'b0, 32'h40, 3'd4, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, AXI_RESP_SLVERR, 1'b1);
    do_read(1'b0, 32'h40, 3'd3, 64'h1122334455667788, AXI_RESP_OKAY, 1'b0);
    do_write(1'b1, 32'h7FF8, 3'd3, 64'h7777_6666_5555_4444, 8'hFF, AXI_RESP_OKAY, 1'b0);
    do_read(1'b1, 32'h7FF8, 3'd3, 64'h7777_6666_5555_4444, AXI_RESP_OKAY, 1'b0);

    // AR, AW and W together: the commit lands as rdata is captured, so read sees the new bytes
    do_write(1'b0, 32'h50, 3'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, AXI_RESP_OKAY, 1'b0);
    check("sim_arready", 64'(arready), 64'd1);
    check("sim_awready", 64'(awready), 64'd1);
    check("sim_wready", 64'(wready), 64'd1);
    b_q.push_back('{id: 1'b0, resp: AXI_RESP_OKAY});
    r_q.push_back('{id: 1'b1, data: 64'h5555_5555_AAAA_AAAA, resp: AXI_RESP_OKAY});
    arvalid = 1'b1; arid = 1'b1; araddr = 32'h50; arsize = 3'd3;
    awvalid = 1'b1; awid = 1'b0; awaddr = 32'h50; awsize = 3'd3;
    wvalid = 1'b1; wdata = 64'h5555_5555_5555_5555; wstrb = 8'hF0;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("b_queue_drained", 64'(b_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
